// File: rtl/memc.sv
// memc -- result-side memory for the systolic matmul.
//
// Captures the diagonally skewed result vector leaving the bottom of the
// DEPTH x DEPTH systolic array and de-skews it into a DEPTH x DEPTH signed
// store. Once the capture window has closed, single elements are read back
// by (row, col) with one cycle of registered latency.
//
// Parameters:
//   BITS_C  signed width of each result element
//   DEPTH   matrix dimension (power of two, >= 2)
//
// Ports:
//   clk    system clock, all state on rising edge
//   rst_n  asynchronous active-low reset
//   start  one-cycle pulse starting a capture window (ignored while capturing)
//   Cin    skewed result lanes from the array, lane j = column j
//   busy   high while the capture window is active
//   done   high from the end of capture until the next accepted start/reset
//   RdEn   read request (served only outside a capture window)
//   row    read row address
//   col    read column address
//   Cout   registered read data, holds when no read is served
//
// Build option:
//   MEMC_ACCUM_EN  when defined, each capture write adds Cin into the stored
//                  element (two's-complement wrap) instead of overwriting it,
//                  so results can be accumulated over several K tiles. Only
//                  reset clears the store in that mode.

module memc #(
    parameter int BITS_C = 24,
    parameter int DEPTH  = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic signed [BITS_C-1:0]       Cin [DEPTH-1:0],
    output logic                           busy,
    output logic                           done,
    input  logic                           RdEn,
    input  logic [$clog2(DEPTH)-1:0]       row,
    input  logic [$clog2(DEPTH)-1:0]       col,
    output logic signed [BITS_C-1:0]       Cout
);

    localparam int AW = $clog2(DEPTH);
    // The counter must reach 2*DEPTH-2, so it needs one more bit than a row index.
    localparam int TW = $clog2(2 * DEPTH);
    localparam logic [TW-1:0] T_LAST = TW'(2 * DEPTH - 2);

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        DONE
    } state_t;

    state_t                   state_q, state_d;
    logic [TW-1:0]            t_q, t_d;
    logic signed [BITS_C-1:0] store_q [DEPTH-1:0][DEPTH-1:0];
    logic signed [BITS_C-1:0] store_d [DEPTH-1:0][DEPTH-1:0];
    logic signed [BITS_C-1:0] cout_q, cout_d;

    // State, capture counter, store and read register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            t_q     <= '0;
            store_q <= '{default: '0};
            cout_q  <= '0;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            store_q <= store_d;
            cout_q  <= cout_d;
        end
    end

    // Next-state logic: start is only honoured outside a capture window, and
    // the window closes on the edge that performs the write for t = 2*DEPTH-2.
    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = CAPTURE;
                    t_d     = '0;
                end
            end
            CAPTURE: begin
                if (t_q == T_LAST) begin
                    state_d = DONE;
                    t_d     = '0;
                end else begin
                    t_d = t_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                t_d     = '0;
            end
        endcase
    end

    // Status outputs follow the state directly, so an asynchronous reset
    // drops busy without waiting for a clock edge.
    always_comb begin
        busy = (state_q == CAPTURE);
        done = (state_q == DONE);
        Cout = cout_q;
    end

    // Datapath: lane j carries row r = t - j while 0 <= r < DEPTH. Reads use
    // the pre-edge store, so a read accepted together with start still returns
    // the previous contents.
    always_comb begin
        store_d = store_q;
        cout_d  = cout_q;
        if (state_q != CAPTURE && RdEn) begin
            cout_d = store_q[row][col];
        end
        if (state_q == CAPTURE) begin
            for (int j = 0; j < DEPTH; j++) begin
                if (t_q >= TW'(j) && (t_q - TW'(j)) < TW'(DEPTH)) begin
`ifdef MEMC_ACCUM_EN
                    store_d[AW'(t_q - TW'(j))][j] = store_q[AW'(t_q - TW'(j))][j] + Cin[j];
`else
                    store_d[AW'(t_q - TW'(j))][j] = Cin[j];
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_memc.sv
// tb_memc -- directed self-checking bench for memc (DEPTH = 8, BITS_C = 24).
// Inputs are driven and outputs sampled on the falling clock edge.

module tb_memc;

    localparam int BITS_C = 24;
    localparam int DEPTH  = 8;

    logic                     clk;
    logic                     rst_n;
    logic                     start;
    logic signed [BITS_C-1:0] cin [DEPTH-1:0];
    logic                     busy;
    logic                     done;
    logic                     rd_en;
    logic [2:0]               row;
    logic [2:0]               col;
    logic signed [BITS_C-1:0] cout;

    int compared;
    int mismatched;

    memc #(
        .BITS_C(BITS_C),
        .DEPTH (DEPTH)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start),
        .Cin  (cin),
        .busy (busy),
        .done (done),
        .RdEn (rd_en),
        .row  (row),
        .col  (col),
        .Cout (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $display("[TB] FAIL %s: observed %0d (0x%h), expected %0d (0x%h)",
                     tag, $signed(obs), obs, $signed(exp), exp);
            $error("[TB] check %s did not match", tag);
        end
    endtask

    // One registered read: request on a falling edge, check after the next rise.
    task automatic read_check(input int r, input int c, input int exp, input string tag);
        @(negedge clk);
        rd_en = 1'b1;
        row   = 3'(r);
        col   = 3'(c);
        @(negedge clk);
        rd_en = 1'b0;
        check_output(tag, 32'(cout), 32'(exp));
    endtask

    // Drive one full capture window. mode 0: Cin = 10r+j in window, mode 1:
    // -(10r+j); -1 outside every lane's window. Optional extras: reset at
    // abort_t, a stray start at restart_t, a read request at rd_t (Cout must
    // hold cout_hold), and a read of (4,6) together with the start pulse.
    task automatic run_capture(input int mode, input int abort_t, input int restart_t,
                               input int rd_t, input int cout_hold,
                               input bit rd_with_start, input int start_rd_exp);
        int busy_cycles;
        int done_seen;
        int r;
        busy_cycles = 0;
        done_seen   = 0;
        @(negedge clk);
        start = 1'b1;
        if (rd_with_start) begin
            rd_en = 1'b1;
            row   = 3'd4;
            col   = 3'd6;
        end
        for (int t = 0; t < 2 * DEPTH - 1; t++) begin
            @(negedge clk);
            start = (t == restart_t);
            rd_en = (t == rd_t);
            if (t == rd_t) begin
                row = 3'd2;
                col = 3'd2;
            end
            if (t == 0 && rd_with_start) check_output("read_with_start", 32'(cout), 32'(start_rd_exp));
            if (t == rd_t + 1) check_output("read_during_capture_hold", 32'(cout), 32'(cout_hold));
            for (int j = 0; j < DEPTH; j++) begin
                r = t - j;
                if (r >= 0 && r < DEPTH) cin[j] = (mode == 0) ? BITS_C'(10 * r + j) : BITS_C'(-(10 * r + j));
                else cin[j] = '1;
            end
            if (busy) busy_cycles++;
            if (done) done_seen++;
            if (t == abort_t) begin
                #1 rst_n = 1'b0;
                #1;
                check_output("abort_busy", {31'b0, busy}, 32'd0);
                check_output("abort_done", {31'b0, done}, 32'd0);
                @(negedge clk);
                rst_n = 1'b1;
                start = 1'b0;
                rd_en = 1'b0;
                return;
            end
        end
        @(negedge clk);
        start = 1'b0;
        rd_en = 1'b0;
        check_output("busy_cycles", 32'(busy_cycles), 32'd15);
        check_output("done_during_capture", 32'(done_seen), 32'd0);
        check_output("busy_after", {31'b0, busy}, 32'd0);
        check_output("done_after", {31'b0, done}, 32'd1);
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        rst_n      = 1'b0;
        start      = 1'b0;
        rd_en      = 1'b0;
        row        = '0;
        col        = '0;
        for (int j = 0; j < DEPTH; j++) cin[j] = '0;

        // Reset, then sweep every address.
        repeat (3) @(negedge clk);
        check_output("reset_cout", 32'(cout), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check_output("reset_busy", {31'b0, busy}, 32'd0);
        check_output("reset_done", {31'b0, done}, 32'd0);
        for (int r = 0; r < DEPTH; r++)
            for (int c = 0; c < DEPTH; c++)
                read_check(r, c, 0, "reset_sweep");

        // Skewed capture and read-back of the de-skewed matrix.
        run_capture(0, -1, -1, -10, 0, 1'b0, 0);
        read_check(3, 5, 35, "cap_3_5");
        read_check(7, 7, 77, "cap_7_7");
        read_check(0, 0, 0, "cap_0_0");
        for (int r = 0; r < DEPTH; r++)
            for (int c = 0; c < DEPTH; c++)
                read_check(r, c, 10 * r + c, "cap_sweep");
        read_check(7, 0, 70, "cap_7_0");

        // Re-capture in DONE with a read attempted mid-window (Cout holds 70)
        // and a stray start at t=3 that must not restart the window.
        run_capture(0, -1, 3, 7, 70, 1'b0, 0);
`ifdef MEMC_ACCUM_EN
        read_check(2, 2, 44, "after_capture_2_2");
`else
        read_check(2, 2, 22, "after_capture_2_2");
`endif

        // Reset asserted at t=6 aborts the capture and clears the store.
        run_capture(0, 6, -1, -10, 0, 1'b0, 0);
        check_output("after_abort_busy", {31'b0, busy}, 32'd0);
        read_check(1, 1, 0, "after_abort_1_1");

        // Fresh capture, then a negated re-capture started alongside a read.
        run_capture(0, -1, -1, -10, 0, 1'b0, 0);
        run_capture(1, -1, -1, -10, 0, 1'b1, 46);
`ifdef MEMC_ACCUM_EN
        read_check(4, 6, 0, "recap_4_6");
        read_check(7, 7, 0, "recap_7_7");
`else
        read_check(4, 6, -46, "recap_4_6");
        read_check(7, 7, -77, "recap_7_7");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    // Watchdog so the run always ends on its own.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/memc.md
Name: memC

Overview:
- Result-side memory for the systolic matmul; the read-out counterpart of the A-operand loader.
- Captures the diagonally skewed result vector leaving the bottom of the DEPTH×DEPTH systolic array and de-skews it into a DEPTH×DEPTH signed store.
- Afterwards serves element-wise reads addressed by (row, col), mirroring the (row, col) write addressing of the operand memories.

Parameters:
BITS_C, 24, signed width of each result element
DEPTH, 8, matrix dimension (rows = cols = array size); power of two, ≥2

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle pulse; begins a capture window
Cin  input  DEPTH x BITS_C (signed, unpacked [DEPTH-1:0])  skewed result lanes from array; lane j = column j
busy  output  1  high while capture window is active
done  output  1  high from end of capture until next accepted start or reset
RdEn  input  1  read request
row  input  $clog2(DEPTH)  read row address
col  input  $clog2(DEPTH)  read column address
Cout  output  BITS_C (signed)  read data

Behaviour:
- Reset (async, rst_n=0): all store entries = 0, FSM = IDLE, capture counter t = 0, busy = 0, done = 0, Cout = 0. Reset asserted mid-capture aborts it; store is left all-zero.
- FSM states: IDLE, CAPTURE, DONE.
- IDLE/DONE --start--> CAPTURE, with t = 0, busy = 1, done = 0. start while in CAPTURE is ignored.
- Capture window is 2*DEPTH-1 cycles, t = 0 .. 2*DEPTH-2, one rising edge per t. At each edge, for every lane j with r = t-j and 0 ≤ r < DEPTH: store[r][j] <= Cin[j]. Lanes outside their window are ignored, so lane j is live for t = j .. j+DEPTH-1.
- On the edge with t = 2*DEPTH-2: last write, then FSM -> DONE, busy = 0, done = 1 starting the next cycle. Total capture latency is start edge + 2*DEPTH-1 edges.
- A new start in DONE re-captures and overwrites every entry.
- Reads: in IDLE or DONE, RdEn=1 at an edge gives Cout = store[row][col] after that edge (1-cycle registered latency).
- RdEn=0 holds Cout. RdEn during CAPTURE is ignored and Cout holds.
- A read and a start on the same edge: the read is served (pre-capture data) and the capture begins.
- Address wrap: row/col span exactly DEPTH values; no out-of-range case exists.
- Widths: Cin is stored bit-exact. No arithmetic occurs unless the optional feature is enabled.

Optional Feature:
- Macro: MEMC_ACCUM_EN.
- Defined: each capture write becomes store[r][j] <= store[r][j] + Cin[j], BITS_C two's-complement wrap, no saturation. This supports K-tiled matmul across multiple capture windows. Only reset clears the store; start does not.
- Undefined: plain overwrite as described in Behaviour.

Test Plan:
1. Reset: hold rst_n=0, release. RdEn sweep over all 64 addresses (DEPTH=8) -> Cout=0 each time, busy=0, done=0.
2. Skewed capture: pulse start; at cycle t drive Cin[j] = 10*(t-j)+j inside each lane's window and -1 outside. Then expect busy high for exactly 15 cycles and done=1 afterwards. Read (3,5) -> 35, (7,7) -> 77, (0,0) -> 0, (7,0) -> 70; no entry = -1.
3. Read during capture: RdEn=1 with (2,2) mid-window -> Cout unchanged from its prior value. After done, read (2,2) -> 22.
4. Reset mid-capture: assert rst_n=0 at t=6 -> busy=0 immediately. After release, read (1,1) -> 0.
5. Re-capture: second start with Cin[j] = -(10*r+j) in window. Read (4,6) -> -46 (overwrite); with MEMC_ACCUM_EN defined -> 0.
6. Start ignored: pulse start again at t=3 of an active capture -> window still ends at t=14, done asserts once.
